exu_wb: RTL and testbench

EXU_WB -- requirements
Module: exu_wb

---
 rtl/exu_wb_pkg.sv | 32 +++
 rtl/exu_wb_if.sv | 38 +++
 rtl/exu_wb_ld_ext.sv | 52 +++++
 rtl/exu_wb.sv | 138 +++++++++++++
 tb/tb_exu_wb.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/exu_wb_pkg.sv
// Shared encodings for the execute-stage writeback unit: source select,
// load size and FSM state.
package exu_wb_pkg;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ALU  = 2'd1,
    SEL_IMM  = 2'd2,
    SEL_MEM  = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2,
    LD_D = 2'd3
  } ld_size_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;

  localparam int XLEN_DEF = 32;
  localparam int RA_W_DEF = 5;

  // A 32-bit datapath has only four byte lanes, so the top offset bit is dropped.
  function automatic logic [2:0] eff_offset(input logic [2:0] offset, input int xlen);
    return (xlen == 32) ? {1'b0, offset[1:0]} : offset;
  endfunction

endpackage

// File: rtl/exu_wb_if.sv
// Request, load-return and register-file write signals of the writeback unit.
// The master side issues requests and load data; the slave side is exu_wb.
interface exu_wb_if
  import exu_wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) ();

  logic            in_valid;
  logic            in_ready;
  logic [RA_W-1:0] in_rd;
  wb_sel_e         in_sel;
  ld_size_e        in_ld_size;
  logic            in_ld_unsigned;
  logic [2:0]      in_addr_lo;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] imm;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_r;
  logic            gpr_w_en;
  logic [RA_W-1:0] gpr_w_addr;
  logic [XLEN-1:0] gpr_w_data;
  logic            load_err;

  modport master (
    output in_valid, in_rd, in_sel, in_ld_size, in_ld_unsigned, in_addr_lo,
           alu_result, imm, mem_rvalid, mem_r,
    input  in_ready, gpr_w_en, gpr_w_addr, gpr_w_data, load_err
  );

  modport slave (
    input  in_valid, in_rd, in_sel, in_ld_size, in_ld_unsigned, in_addr_lo,
           alu_result, imm, mem_rvalid, mem_r,
    output in_ready, gpr_w_en, gpr_w_addr, gpr_w_data, load_err
  );

endinterface

// File: rtl/exu_wb_ld_ext.sv
// Combinational load extraction: selects the addressed byte/half/word/double
// from the raw load word, extends it to XLEN and flags misalignment.
module exu_wb_ld_ext
  import exu_wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      offset,
  input  ld_size_e        size,
  input  logic            ld_unsigned,
  output logic [XLEN-1:0] value,
  output logic            misaligned
);

  logic [2:0]      off;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic            sign;

  assign off     = eff_offset(offset, XLEN);
  assign shifted = data >> {off, 3'b000};

  // Extension is done with a keep-mask so no zero-width replication appears for any XLEN.
  always_comb begin
    mask       = '1;
    sign       = shifted[XLEN-1];
    misaligned = 1'b0;
    case (size)
      LD_B: begin
        mask = XLEN'(8'hFF);
        sign = shifted[7];
      end
      LD_H: begin
        mask       = XLEN'(16'hFFFF);
        sign       = shifted[15];
        misaligned = off[0];
      end
      LD_W: begin
        mask       = XLEN'(32'hFFFF_FFFF);
        sign       = shifted[31];
        misaligned = |off[1:0];
      end
      LD_D: begin
        misaligned = (XLEN == 32) || (off != 3'd0);
      end
      default: ;
    endcase
    value = (shifted & mask) | ((sign && !ld_unsigned) ? ~mask : '0);
  end

endmodule

// File: rtl/exu_wb.sv
// Execute-stage writeback unit: ALU/IMM results are written the cycle after
// accept; loads wait for mem_rvalid. Optional bypass outputs under EXU_WB_FWD_EN.
//
// state       | meaning
// ST_IDLE     | ready for a request; ALU/IMM writes issue back-to-back
// ST_WAIT_MEM | load accepted, holding captured fields until mem_rvalid
module exu_wb
  import exu_wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
`ifdef EXU_WB_FWD_EN
  output logic            fwd_valid,
  output logic [RA_W-1:0] fwd_addr,
  output logic [XLEN-1:0] fwd_data,
`endif
  exu_wb_if.slave         wb
);

  wb_state_e       state, state_nx;
  logic            accept;
  logic            cap_en;
  logic [RA_W-1:0] cap_rd;
  ld_size_e        cap_size;
  logic            cap_uns;
  logic [2:0]      cap_off;

  logic            w_en, w_en_nx;
  logic [RA_W-1:0] w_addr, w_addr_nx;
  logic [XLEN-1:0] w_data, w_data_nx;
  logic            err, err_nx;

  logic [XLEN-1:0] ld_value;
  logic            ld_mis;

  assign wb.in_ready = (state == ST_IDLE);
  assign accept      = wb.in_valid && wb.in_ready;

  exu_wb_ld_ext #(.XLEN(XLEN)) u_ld_ext (
    .data       (wb.mem_r),
    .offset     (cap_off),
    .size       (cap_size),
    .ld_unsigned(cap_uns),
    .value      (ld_value),
    .misaligned (ld_mis)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      w_en   <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      w_en   <= w_en_nx;
      w_addr <= w_addr_nx;
      w_data <= w_data_nx;
      err    <= err_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_rd   <= '0;
      cap_size <= LD_B;
      cap_uns  <= 1'b0;
      cap_off  <= '0;
    end else if (cap_en) begin
      cap_rd   <= wb.in_rd;
      cap_size <= wb.in_ld_size;
      cap_uns  <= wb.in_ld_unsigned;
      cap_off  <= wb.in_addr_lo;
    end
  end

  // x0 writes still run the handshake but never raise the write strobe.
  always_comb begin
    state_nx  = state;
    w_en_nx   = 1'b0;
    w_addr_nx = w_addr;
    w_data_nx = w_data;
    err_nx    = 1'b0;
    cap_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (wb.in_sel)
            SEL_ALU: begin
              w_en_nx   = |wb.in_rd;
              w_addr_nx = wb.in_rd;
              w_data_nx = wb.alu_result;
            end
            SEL_IMM: begin
              w_en_nx   = |wb.in_rd;
              w_addr_nx = wb.in_rd;
              w_data_nx = wb.imm;
            end
            SEL_MEM: begin
              cap_en   = 1'b1;
              state_nx = ST_WAIT_MEM;
            end
            default: ;
          endcase
        end
      end
      ST_WAIT_MEM: begin
        if (wb.mem_rvalid) begin
          state_nx = ST_IDLE;
          if (ld_mis) begin
            err_nx = 1'b1;
          end else begin
            w_en_nx   = |cap_rd;
            w_addr_nx = cap_rd;
            w_data_nx = ld_value;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign wb.gpr_w_en   = w_en;
  assign wb.gpr_w_addr = w_addr;
  assign wb.gpr_w_data = w_data;
  assign wb.load_err   = err;

`ifdef EXU_WB_FWD_EN
  assign fwd_valid = w_en;
  assign fwd_addr  = w_addr;
  assign fwd_data  = w_data;
`endif

endmodule

// File: tb/tb_exu_wb.sv
// Scoreboard bench for exu_wb: directed requests push expected writes/errors,
// a negedge monitor pops and compares whenever a write or load_err appears.
module tb_exu_wb;
  import exu_wb_pkg::*;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;

  exu_wb_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

`ifdef EXU_WB_FWD_EN
  logic            fwd_valid;
  logic [RA_W-1:0] fwd_addr;
  logic [XLEN-1:0] fwd_data;
`endif

  exu_wb #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef EXU_WB_FWD_EN
    .fwd_valid(fwd_valid),
    .fwd_addr (fwd_addr),
    .fwd_data (fwd_data),
`endif
    .wb       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              err;
    logic [RA_W-1:0] addr;
    logic [XLEN-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.gpr_w_en && bus.load_err) begin
        check("w_en_err_exclusive", 64'(bus.gpr_w_en & bus.load_err), 64'd0);
      end else if (bus.gpr_w_en || bus.load_err) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 64'({bus.gpr_w_en, bus.load_err}), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("load_err", 64'(bus.load_err), 64'(mon_e.err));
          if (!mon_e.err) begin
            check("w_addr", 64'(bus.gpr_w_addr), 64'(mon_e.addr));
            check("w_data", 64'(bus.gpr_w_data), 64'(mon_e.data));
          end
        end
      end
    end
  end

`ifdef EXU_WB_FWD_EN
  always @(negedge clk) begin
    check("fwd_valid", 64'(fwd_valid), 64'(bus.gpr_w_en));
    check("fwd_addr", 64'(fwd_addr), 64'(bus.gpr_w_addr));
    check("fwd_data", 64'(fwd_data), 64'(bus.gpr_w_data));
  end
`endif

  task automatic drive_idle();
    bus.in_valid       = 1'b0;
    bus.in_sel         = SEL_NONE;
    bus.in_rd          = '0;
    bus.in_ld_size     = LD_B;
    bus.in_ld_unsigned = 1'b0;
    bus.in_addr_lo     = 3'd0;
    bus.alu_result     = '0;
    bus.imm            = '0;
    bus.mem_rvalid     = 1'b0;
    bus.mem_r          = '0;
  endtask

  task automatic issue(input wb_sel_e sel, input logic [RA_W-1:0] rd,
                       input logic [XLEN-1:0] alu, input logic [XLEN-1:0] im);
    bus.in_valid   = 1'b1;
    bus.in_sel     = sel;
    bus.in_rd      = rd;
    bus.alu_result = alu;
    bus.imm        = im;
    check("in_ready_idle", 64'(bus.in_ready), 64'd1);
    if (rd != '0 && sel == SEL_ALU) sb.push_back('{err: 1'b0, addr: rd, data: alu});
    if (rd != '0 && sel == SEL_IMM) sb.push_back('{err: 1'b0, addr: rd, data: im});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic mem_load(input logic [RA_W-1:0] rd, input ld_size_e size, input logic uns,
                          input logic [2:0] off, input logic [XLEN-1:0] word,
                          input bit exp_err, input logic [XLEN-1:0] exp_data);
    bus.in_valid       = 1'b1;
    bus.in_sel         = SEL_MEM;
    bus.in_rd          = rd;
    bus.in_ld_size     = size;
    bus.in_ld_unsigned = uns;
    bus.in_addr_lo     = off;
    check("in_ready_idle", 64'(bus.in_ready), 64'd1);
    if (exp_err) sb.push_back('{err: 1'b1, addr: '0, data: '0});
    else if (rd != '0) sb.push_back('{err: 1'b0, addr: rd, data: exp_data});
    @(posedge clk); #1;
    // keep a competing request asserted while waiting; it must not be taken
    bus.in_sel         = SEL_ALU;
    bus.in_rd          = 5'd31;
    bus.alu_result     = 32'hBAD0_BAD0;
    bus.in_ld_size     = LD_D;
    bus.in_ld_unsigned = ~uns;
    bus.in_addr_lo     = 3'd7;
    check("in_ready_wait", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    check("in_ready_wait", 64'(bus.in_ready), 64'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_r      = word;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    bus.mem_r      = '0;
    bus.in_valid   = 1'b0;
    check("in_ready_after_rvalid", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_w_en", 64'(bus.gpr_w_en), 64'd0);
    check("rst_load_err", 64'(bus.load_err), 64'd0);
    check("rst_w_addr", 64'(bus.gpr_w_addr), 64'd0);
    check("rst_w_data", 64'(bus.gpr_w_data), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    issue(SEL_ALU, 5'd5, 32'h0000_1234, 32'h0);
    issue(SEL_IMM, 5'd9, 32'h0, 32'hDEAD_BEEF);
    issue(SEL_NONE, 5'd3, 32'h1111_1111, 32'h2222_2222);
    drain();

    mem_load(5'd10, LD_B, 1'b1, 3'd2, 32'h80FF_7F00, 1'b0, 32'h0000_00FF);
    mem_load(5'd11, LD_B, 1'b0, 3'd3, 32'h80FF_7F00, 1'b0, 32'hFFFF_FF80);
    mem_load(5'd12, LD_H, 1'b0, 3'd1, 32'h80FF_7F00, 1'b1, 32'h0);
    mem_load(5'd13, LD_D, 1'b0, 3'd0, 32'h80FF_7F00, 1'b1, 32'h0);
    mem_load(5'd14, LD_W, 1'b0, 3'd2, 32'h80FF_7F00, 1'b1, 32'h0);
    mem_load(5'd15, LD_H, 1'b1, 3'd2, 32'h80FF_7F00, 1'b0, 32'h0000_80FF);
    mem_load(5'd16, LD_H, 1'b0, 3'd2, 32'h80FF_7F00, 1'b0, 32'hFFFF_80FF);
    mem_load(5'd17, LD_W, 1'b0, 3'd4, 32'h80FF_7F00, 1'b0, 32'h80FF_7F00);
    mem_load(5'd18, LD_B, 1'b0, 3'd5, 32'h80FF_7F00, 1'b0, 32'h0000_007F);
    mem_load(5'd19, LD_H, 1'b1, 3'd6, 32'h1234_ABCD, 1'b0, 32'h0000_1234);
    mem_load(5'd0,  LD_W, 1'b0, 3'd0, 32'h1234_ABCD, 1'b0, 32'h0);
    drain();

    issue(SEL_ALU, 5'd0, 32'hAAAA_AAAA, 32'h0);
    issue(SEL_ALU, 5'd7, 32'h0000_0077, 32'h0);
    issue(SEL_IMM, 5'd8, 32'h0, 32'h8888_0008);
    drain();

    bus.mem_rvalid = 1'b1;
    bus.mem_r      = 32'h5555_5555;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_rvalid_ready", 64'(bus.in_ready), 64'd1);
    drain();

    bus.in_valid   = 1'b1;
    bus.in_sel     = SEL_MEM;
    bus.in_rd      = 5'd20;
    bus.in_ld_size = LD_W;
    bus.in_addr_lo = 3'd0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("wait_ready_low", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    #2;
    check("rst_wait_ready", 64'(bus.in_ready), 64'd1);
    check("rst_wait_w_en", 64'(bus.gpr_w_en), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b1;
    bus.mem_r      = 32'h0BAD_F00D;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    check("post_rst_ready", 64'(bus.in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", 64'(bus.in_ready), 64'd1);
    drain();

`ifdef EXU_WB_FWD_EN
    for (int i = 0; i < 1000; i++) begin
      issue(wb_sel_e'(2'($urandom_range(0, 2))), 5'($urandom_range(0, 31)),
            32'($urandom), 32'($urandom));
    end
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
